// File: rtl/dht11_uart_reporter.sv
// DHT11 reporter: formats each measurement as "RH=hhh T=ttt" or "ERR" plus EOL on a byte UART; DHT11_RPT_SEQ_EN adds a "#NN " sequence prefix.
// Latency: done rise to first tx_start is 10 cycles for a valid sample (8-cycle BCD convert) and 2 cycles for an invalid one.
// Backpressure: one byte in flight; holds in LOAD while tx_busy=1 and steps on each busy high->low. A done edge while busy is dropped and sets overflow.
module dht11_uart_reporter #(
   parameter bit EOL_CRLF = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dht11_done,
   input  logic       dht11_valid,
   input  logic [7:0] rhdata,
   input  logic [7:0] t_data,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic       overflow
);

`ifdef DHT11_RPT_SEQ_EN
   localparam int PRE_LEN = 4;
   localparam int IDX_W   = 5;
`else
   localparam int PRE_LEN = 0;
   localparam int IDX_W   = 4;
`endif
   localparam int EOL_LEN = EOL_CRLF ? 2 : 1;
   localparam logic [IDX_W-1:0] PRE      = IDX_W'(PRE_LEN);
   localparam logic [IDX_W-1:0] LAST_OK  = IDX_W'(PRE_LEN + 12 + EOL_LEN - 1);
   localparam logic [IDX_W-1:0] LAST_ERR = IDX_W'(PRE_LEN + 3 + EOL_LEN - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CONVERT = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_WAIT_HI = 3'd3;
   localparam logic [2:0] S_WAIT_LO = 3'd4;

   logic [2:0]       state;
   logic             done_d;
   logic             done_rise;
   logic             valid_q;
   logic [19:0]      dd_h;
   logic [19:0]      dd_t;
   logic [2:0]       conv_cnt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] pos;
   logic [IDX_W-1:0] body_len;
   logic [7:0]       body_byte;
   logic [7:0]       cur_byte;
   logic             last_byte;
`ifdef DHT11_RPT_SEQ_EN
   logic [7:0]       seq_q;
   logic [7:0]       pre_byte;
`endif

   // One double-dabble step: BCD in [19:8], remaining binary in [7:0].
   function automatic logic [19:0] dd_step(input logic [19:0] v);
      logic [19:0] r;
      r = v;
      for (int k = 0; k < 3; k++) begin
         if (r[8+4*k +: 4] >= 4'd5) r[8+4*k +: 4] = r[8+4*k +: 4] + 4'd3;
      end
      return {r[18:0], 1'b0};
   endfunction

   function automatic logic [7:0] dig(input logic [3:0] n);
      return 8'h30 + {4'h0, n};
   endfunction

`ifdef DHT11_RPT_SEQ_EN
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction
`endif

   assign done_rise = dht11_done & ~done_d;
   assign busy      = (state != S_IDLE);

   always_comb begin
      pos       = idx - PRE;
      body_len  = valid_q ? IDX_W'(12) : IDX_W'(3);
      last_byte = valid_q ? (idx == LAST_OK) : (idx == LAST_ERR);
      body_byte = "R";
      if (valid_q) begin
         case (pos[3:0])
            4'd0:    body_byte = "R";
            4'd1:    body_byte = "H";
            4'd2:    body_byte = "=";
            4'd3:    body_byte = dig(dd_h[19:16]);
            4'd4:    body_byte = dig(dd_h[15:12]);
            4'd5:    body_byte = dig(dd_h[11:8]);
            4'd6:    body_byte = " ";
            4'd7:    body_byte = "T";
            4'd8:    body_byte = "=";
            4'd9:    body_byte = dig(dd_t[19:16]);
            4'd10:   body_byte = dig(dd_t[15:12]);
            default: body_byte = dig(dd_t[11:8]);
         endcase
      end else if (pos == IDX_W'(0)) begin
         body_byte = "E";
      end
`ifdef DHT11_RPT_SEQ_EN
      case (idx[1:0])
         2'd0:    pre_byte = "#";
         2'd1:    pre_byte = hex_ascii(seq_q[7:4]);
         2'd2:    pre_byte = hex_ascii(seq_q[3:0]);
         default: pre_byte = " ";
      endcase
`endif
      cur_byte = 8'h0A;
`ifdef DHT11_RPT_SEQ_EN
      if (idx < PRE) cur_byte = pre_byte;
      else
`endif
      if (pos < body_len) cur_byte = body_byte;
      else if (EOL_CRLF && (pos == body_len)) cur_byte = 8'h0D;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         done_d   <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         overflow <= 1'b0;
         valid_q  <= 1'b0;
         dd_h     <= '0;
         dd_t     <= '0;
         conv_cnt <= '0;
         idx      <= '0;
`ifdef DHT11_RPT_SEQ_EN
         seq_q    <= 8'h00;
`endif
      end else begin
         done_d   <= dht11_done;
         tx_start <= 1'b0;
         if (done_rise && (state != S_IDLE)) overflow <= 1'b1;
         case (state)
            S_IDLE: begin
               if (done_rise) begin
                  dd_h     <= {12'h000, rhdata};
                  dd_t     <= {12'h000, t_data};
                  valid_q  <= dht11_valid;
                  conv_cnt <= '0;
                  idx      <= '0;
                  state    <= dht11_valid ? S_CONVERT : S_LOAD;
               end
            end
            S_CONVERT: begin
               dd_h     <= dd_step(dd_h);
               dd_t     <= dd_step(dd_t);
               conv_cnt <= conv_cnt + 3'd1;
               if (conv_cnt == 3'd7) state <= S_LOAD;
            end
            S_LOAD: begin
               if (!tx_busy) begin
                  tx_data  <= cur_byte;
                  tx_start <= 1'b1;
                  state    <= S_WAIT_HI;
               end
            end
            S_WAIT_HI: begin
               if (tx_busy) state <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               if (!tx_busy) begin
                  if (last_byte) begin
                     state <= S_IDLE;
`ifdef DHT11_RPT_SEQ_EN
                     seq_q <= seq_q + 8'd1;
`endif
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     state <= S_LOAD;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// Bench for dht11_uart_reporter: behavioural UART model with a byte scoreboard fed by a text-level line model.
// Directed plan cases plus randomized reports; honours DHT11_RPT_SEQ_EN when defined.
module tb_dht11_uart_reporter;
   localparam bit EOL_CRLF = 1'b1;

   logic       clk = 1'b0;
   logic       rst;
   logic       dht11_done;
   logic       dht11_valid;
   logic [7:0] rhdata;
   logic [7:0] t_data;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;
   logic       overflow;

   logic       uart_busy;
   logic       hold_busy;
   int         busy_len;
   int         rx_cnt = 0;
   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] model_seq = 8'h00;

   assign tx_busy = uart_busy | hold_busy;

   always #5 clk = ~clk;

   dht11_uart_reporter #(.EOL_CRLF(EOL_CRLF)) dut (
      .clk(clk), .rst(rst), .dht11_done(dht11_done), .dht11_valid(dht11_valid),
      .rhdata(rhdata), .t_data(t_data), .tx_busy(tx_busy), .tx_start(tx_start),
      .tx_data(tx_data), .busy(busy), .overflow(overflow)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   // Expected line written as text, then queued byte by byte.
   task automatic push_line(input logic [7:0] rh, input logic [7:0] t, input bit v);
      string s;
      s = v ? $sformatf("RH=%03d T=%03d", rh, t) : "ERR";
`ifdef DHT11_RPT_SEQ_EN
      s = {$sformatf("#%02X ", model_seq), s};
      model_seq = model_seq + 8'd1;
`endif
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      if (EOL_CRLF) exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // UART model and scoreboard monitor.
   initial begin
      logic [7:0] b;
      logic [7:0] e;
      uart_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            b = tx_data;
            rx_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_byte got=0x%02h expected=none", b);
            end else begin
               e = exp_q.pop_front();
               if (b !== e) begin
                  failures++;
                  $display("FAIL tx_byte got=0x%02h expected=0x%02h", b, e);
               end
            end
            uart_busy = 1'b1;
            @(negedge clk);
            chk("tx_start_width", {31'd0, tx_start}, 32'd0);
            for (int i = 1; i < busy_len; i++) begin
               @(negedge clk);
               if (busy === 1'b1) chk("tx_data_stable", {24'd0, tx_data}, {24'd0, b});
            end
            uart_busy = 1'b0;
         end
      end
   end

   // lat_mode: 0 none, 1 exactly 2 cycles, 2 at most 34 cycles.
   task automatic send(input logic [7:0] rh, input logic [7:0] t, input bit v,
                       input bit accept, input int lat_mode);
      int k;
      @(negedge clk);
      rhdata = rh; t_data = t; dht11_valid = v; dht11_done = 1'b1;
      if (accept) push_line(rh, t, v);
      @(negedge clk);
      dht11_done = 1'b0;
      rhdata = 8'($urandom); t_data = 8'($urandom); dht11_valid = 1'($urandom);
      k = 1;
      if (lat_mode != 0) begin
         while (tx_start !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
         end
         if (lat_mode == 1) chk("latency_err", k, 2);
         else               chk("latency_ok_le34", {31'd0, (k <= 34)}, 32'd1);
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_idle"}, {31'd0, busy}, 32'd0);
      chk({name, "_all_bytes"}, exp_q.size(), 0);
   endtask

   task automatic wait_rx(input int target, input int budget, input string name);
      int k = 0;
      while (rx_cnt < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_rx_reached"}, {31'd0, (rx_cnt >= target)}, 32'd1);
   endtask

   initial begin
      int base;
      logic [7:0] r_rh;
      logic [7:0] r_t;
      bit r_v;
      rst = 1'b1; dht11_done = 1'b0; dht11_valid = 1'b0;
      rhdata = 8'h00; t_data = 8'h00; hold_busy = 1'b0; busy_len = 4;
      repeat (3) @(negedge clk);
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      busy_len = 10;
      send(8'd45, 8'd23, 1'b1, 1'b1, 2);
      wait_idle(1000, "rh45_t23");
      chk("rh45_overflow", {31'd0, overflow}, 32'd0);

      send(8'd45, 8'd23, 1'b0, 1'b1, 1);
      wait_idle(1000, "err");

      busy_len = 3;
      send(8'd255, 8'd0, 1'b1, 1'b1, 2);
      wait_idle(1000, "rh255_t0");
      send(8'd9, 8'd100, 1'b1, 1'b1, 2);
      wait_idle(1000, "rh9_t100");

      // Second done edge while byte 5 is on the wire.
      busy_len = 6;
      base = rx_cnt;
      send(8'd12, 8'd34, 1'b1, 1'b1, 0);
      wait_rx(base + 5, 1000, "ovf_byte5");
      send(8'd99, 8'd98, 1'b1, 1'b0, 0);
      wait_idle(1000, "ovf_line");
      repeat (60) @(negedge clk);
      chk("ovf_no_second_line", rx_cnt - base, 12 + (EOL_CRLF ? 2 : 1)
`ifdef DHT11_RPT_SEQ_EN
          + 4
`endif
          );
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Reset in WAIT_LO of byte 7.
      busy_len = 8;
      base = rx_cnt;
      send(8'd77, 8'd66, 1'b1, 1'b1, 0);
      wait_rx(base + 7, 1000, "abort_byte7");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_tx_start", {31'd0, tx_start}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_overflow", {31'd0, overflow}, 32'd0);
      chk("abort_tx_data", {24'd0, tx_data}, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      model_seq = 8'h00;
      repeat (12) @(negedge clk);
      chk("abort_no_more_bytes", rx_cnt - base, 7);
      busy_len = 4;
      send(8'd45, 8'd23, 1'b1, 1'b1, 2);
      wait_idle(1000, "after_abort");

      // Transmitter busy before the first LOAD.
      hold_busy = 1'b1;
      base = rx_cnt;
      send(8'd50, 8'd60, 1'b1, 1'b1, 0);
      repeat (500) @(negedge clk);
      chk("hold_no_start", rx_cnt - base, 0);
      hold_busy = 1'b0;
      wait_idle(1000, "hold_release");

      for (int n = 0; n < 20; n++) begin
         r_rh = 8'($urandom);
         r_t = 8'($urandom);
         r_v = ($urandom_range(0, 3) != 0);
         busy_len = $urandom_range(1, 6);
         send(r_rh, r_t, r_v, 1'b1, r_v ? 2 : 1);
         wait_idle(1000, "rand");
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      chk("final_overflow", {31'd0, overflow}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dht11_uart_reporter.md
Name: dht11_uart_reporter

Overview:
- Downstream consumer of the DHT11 controller.
- On each completed measurement it captures humidity, temperature and checksum status, converts them to ASCII decimal, and streams a fixed-format text line to a byte-wide UART transmitter via a start/busy handshake.
- Sits beside the FND path in the top level, fed by the same controller outputs, and drives the existing UART TX block.

Parameters:
- EOL_CRLF, 1, line terminator: 1 = "\r\n" (0x0D 0x0A), 0 = "\n" (0x0A) only.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- dht11_done  input  1  measurement-complete indication from DHT11 controller; level or pulse, rising edge used
- dht11_valid  input  1  checksum OK, sampled with data at done rising edge
- rhdata  input  8  humidity integer byte
- t_data  input  8  temperature integer byte
- tx_busy  input  1  UART TX busy
- tx_start  output  1  one-cycle request to send tx_data
- tx_data  output  8  byte to transmit, stable from tx_start until tx_busy falls
- busy  output  1  report in progress (state != IDLE)
- overflow  output  1  sticky: a done edge arrived while busy; cleared only by rst

Behaviour:
- All state updates on posedge clk. rst=1 forces: state IDLE, tx_start=0, tx_data=0x00, busy=0, overflow=0, done edge register=0, capture registers=0.
- Edge detect: done_rise = dht11_done & ~done_d, with done_d registered every cycle.
- States: IDLE -> CONVERT -> LOAD -> WAIT_HI -> WAIT_LO -> (LOAD, or IDLE after last byte).
- IDLE:
  - on done_rise, capture rhdata, t_data, dht11_valid.
  - If valid, go to CONVERT; else go to LOAD with the error message selected.
- CONVERT:
  - binary-to-3-digit BCD for both bytes, by iterative subtraction or double-dabble.
  - Must finish within 32 cycles of entry and be exact for 0..255.
- Valid message, 14 bytes with CRLF: "RH=" h2 h1 h0 " T=" t2 t1 t0 EOL.
  - Digits are ASCII 0x30+d, leading zeros kept, e.g. 7 -> "007".
- Invalid message, 5 bytes with CRLF: "ERR" EOL.
- With EOL_CRLF=0, drop the 0x0D byte: lengths become 13 and 4.
- LOAD:
  - when tx_busy==0, drive tx_data=current byte and pulse tx_start for exactly 1 cycle, then go to WAIT_HI.
  - If tx_busy==1, hold in LOAD with tx_start=0.
- WAIT_HI: wait for tx_busy==1. The UART must assert busy within 1 cycle of tx_start.
- WAIT_LO:
  - wait for tx_busy==0, then advance the byte index.
  - If the last byte was sent, go to IDLE; else go to LOAD.
- tx_data holds its value until the next LOAD update.
- Byte index counter is 4 bits and resets to 0 on each new report.
- done_rise in any state other than IDLE:
  - the event is ignored, captured data is unchanged, and overflow is set to 1.
- done_rise in the same cycle the FSM returns to IDLE is also dropped; the event must arrive while already in IDLE to be accepted.
- rst mid-message: immediate abort, no further bytes, tx_start=0 in the same cycle. Any partially sent line is not resumed.
- Latency from done_rise to first tx_start:
  - valid: at most 34 cycles with tx_busy=0.
  - invalid: 2 cycles.
- busy=1 from the cycle after done_rise until the cycle after the final tx_busy fall.

Optional Feature:
- Macro: DHT11_RPT_SEQ_EN.
- Defined:
  - an 8-bit report sequence counter, reset 0, increments by 1 after each completed line (valid or ERR) and wraps 0xFF->0x00.
  - Each line is prefixed "#" + two uppercase hex ASCII digits + " " (4 extra bytes), e.g. "#0A RH=045 T=023\r\n".
  - The counter does not increment on aborted lines.
- Undefined: no counter logic and no prefix; lengths as above.

Test Plan:
- rhdata=45, t_data=23, valid=1, tx_busy model 10 cycles -> tx bytes 52 48 3D 30 34 35 20 54 3D 30 32 33 0D 0A, then busy=0, overflow=0.
- valid=0 -> bytes 45 52 52 0D 0A only; CONVERT skipped; first tx_start 2 cycles after done rise.
- rhdata=255, t_data=0 -> "RH=255 T=000\r\n"; rhdata=9, t_data=100 -> "RH=009 T=100\r\n".
- Second done rise during byte 5 of a report -> current line completes unchanged, no second line, overflow=1 until rst.
- rst asserted during WAIT_LO of byte 7 -> next cycle tx_start=0, busy=0, overflow=0; a new done rise then yields a full 14-byte line from "R".
- tx_busy held 1 for 500 cycles before the first LOAD -> no tx_start until it drops; EOL_CRLF=0 build -> 13-byte line ending 0A.
